// File: rtl/branch_target_buffer_assoc_if.sv
// Fetch/resolve-side bundle for the set-associative BTB.
// The master drives lookup PC and training; the slave (BTB) returns the prediction.
interface branch_target_buffer_assoc_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc;
    logic            hit;
    logic            predict_taken;
    logic [XLEN-1:0] target;
    logic            upd_valid;
    logic [6:0]      upd_opcode;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            flush;

    modport master (
        output pc, upd_valid, upd_opcode, upd_pc, upd_taken, upd_target, flush,
        input  hit, predict_taken, target
    );

    modport slave (
        input  pc, upd_valid, upd_opcode, upd_pc, upd_taken, upd_target, flush,
        output hit, predict_taken, target
    );
endinterface

// File: rtl/branch_target_buffer_assoc.sv
// Set-associative branch target buffer: tagged ways, saturating direction
// counters, true-LRU replacement, combinational lookup, registered training.

// Per-way tag comparator, instantiated once per way for both the lookup
// port and the training port.
module btb_way_match #(
    parameter int TW = 24
) (
    input  logic          vld_i,
    input  logic [TW-1:0] tag_a_i,
    input  logic [TW-1:0] tag_b_i,
    output logic          match_o
);
    assign match_o = vld_i && (tag_a_i == tag_b_i);
endmodule

module branch_target_buffer_assoc #(
    parameter int XLEN     = 32,
    parameter int SETS     = 64,
    parameter int WAYS     = 2,
    parameter int CTR_BITS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    branch_target_buffer_assoc_if.slave   bus
);
    localparam int IDX = $clog2(SETS);
    localparam int TW  = XLEN - IDX - 2;
    // WAYS=1 keeps a dummy 1-bit age that is always 0.
    localparam int AW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [6:0]          OP_BRANCH = 7'b1100011;
    localparam logic [6:0]          OP_JAL    = 7'b1101111;
    localparam logic [CTR_BITS-1:0] CTR_MAX   = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK  = CTR_BITS'(1) << (CTR_BITS - 1);

    // Storage
    logic [SETS-1:0][WAYS-1:0]               vld_q;
    logic [SETS-1:0][WAYS-1:0][TW-1:0]       tag_q;
    logic [SETS-1:0][WAYS-1:0][XLEN-1:0]     tgt_q;
    logic [SETS-1:0][WAYS-1:0][CTR_BITS-1:0] ctr_q;
    logic [SETS-1:0][WAYS-1:0][AW-1:0]       age_q;

    // Address split
    logic [IDX-1:0] lk_idx, up_idx;
    logic [TW-1:0]  lk_tag, up_tag;
    logic           unused_lo_bits;

    assign lk_idx = bus.pc[IDX+1:2];
    assign lk_tag = bus.pc[XLEN-1:IDX+2];
    assign up_idx = bus.upd_pc[IDX+1:2];
    assign up_tag = bus.upd_pc[XLEN-1:IDX+2];
    // Instruction-alignment bits never participate in indexing or tagging.
    assign unused_lo_bits = ^{bus.pc[1:0], bus.upd_pc[1:0]};

    logic [WAYS-1:0] lk_match, up_match;

    for (genvar w = 0; w < WAYS; w++) begin : gen_way
        btb_way_match #(.TW(TW)) u_lk (
            .vld_i   (vld_q[lk_idx][w]),
            .tag_a_i (tag_q[lk_idx][w]),
            .tag_b_i (lk_tag),
            .match_o (lk_match[w])
        );
        btb_way_match #(.TW(TW)) u_up (
            .vld_i   (vld_q[up_idx][w]),
            .tag_a_i (tag_q[up_idx][w]),
            .tag_b_i (up_tag),
            .match_o (up_match[w])
        );
    end

    // Lookup: lowest-numbered matching way drives the prediction.
    logic          lk_hit;
    logic [AW-1:0] lk_way;
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_match[w]) begin
                lk_hit = 1'b1;
                lk_way = AW'(w);
            end
        end
    end

    assign bus.hit           = lk_hit;
    assign bus.predict_taken = lk_hit && ctr_q[lk_idx][lk_way][CTR_BITS-1];
    assign bus.target        = lk_hit ? tgt_q[lk_idx][lk_way] : '0;

    // Training: pick hit way or victim (lowest invalid, else oldest).
    logic          up_hit, vic_free, is_br, is_jal, up_we;
    logic [AW-1:0] up_way, vic_way, touch;
    always_comb begin
        up_hit   = 1'b0;
        up_way   = '0;
        vic_free = 1'b0;
        vic_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (up_match[w]) begin
                up_hit = 1'b1;
                up_way = AW'(w);
            end
            if (!vld_q[up_idx][w]) begin
                vic_free = 1'b1;
                vic_way  = AW'(w);
            end
        end
        if (!vic_free) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[up_idx][w] == AW'(WAYS - 1)) vic_way = AW'(w);
            end
        end
        touch = up_hit ? up_way : vic_way;
    end

    assign is_br  = (bus.upd_opcode == OP_BRANCH);
    assign is_jal = (bus.upd_opcode == OP_JAL);
    // Flush drops any simultaneous training; not-taken misses allocate nothing.
    assign up_we  = bus.upd_valid && (is_br || is_jal) && !bus.flush
                    && (up_hit || bus.upd_taken);

    // Next counter, target and set ages for the touched way.
    logic [CTR_BITS-1:0]       ctr_old, ctr_d;
    logic [XLEN-1:0]           tgt_d;
    logic [AW-1:0]             age_old;
    logic [WAYS-1:0][AW-1:0]   age_d;
    always_comb begin
        ctr_old = ctr_q[up_idx][touch];
        if (is_jal)                ctr_d = CTR_MAX;
        else if (!up_hit)          ctr_d = CTR_WEAK;
        else if (bus.upd_taken)    ctr_d = (ctr_old == CTR_MAX) ? ctr_old : ctr_old + 1'b1;
        else                       ctr_d = (ctr_old == '0) ? ctr_old : ctr_old - 1'b1;

        // A not-taken hit keeps the previously learned target.
        tgt_d = (up_hit && !bus.upd_taken) ? tgt_q[up_idx][touch] : bus.upd_target;

        age_old = age_q[up_idx][touch];
        for (int w = 0; w < WAYS; w++) begin
            if (WAYS == 1 || AW'(w) == touch)       age_d[w] = '0;
            else if (age_q[up_idx][w] < age_old)    age_d[w] = age_q[up_idx][w] + 1'b1;
            else                                    age_d[w] = age_q[up_idx][w];
        end
    end

    // State update: reset / flush / single-way training write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    vld_q[s][w] <= 1'b0;
                    tag_q[s][w] <= '0;
                    tgt_q[s][w] <= '0;
                    ctr_q[s][w] <= '0;
                    age_q[s][w] <= AW'(w);
                end
            end
        end else if (bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    vld_q[s][w] <= 1'b0;
                    age_q[s][w] <= AW'(w);
                end
            end
        end else if (up_we) begin
            vld_q[up_idx][touch] <= 1'b1;
            tag_q[up_idx][touch] <= up_tag;
            tgt_q[up_idx][touch] <= tgt_d;
            ctr_q[up_idx][touch] <= ctr_d;
            age_q[up_idx]        <= age_d;
        end
    end
endmodule

// File: tb/tb_branch_target_buffer_assoc.sv
// Directed bench for the associative BTB; lookups queue their expected
// prediction and a negedge monitor compares against the DUT.
module tb_branch_target_buffer_assoc;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_ALU = 7'b0010011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    branch_target_buffer_assoc_if #(.XLEN(32)) bus ();

    branch_target_buffer_assoc #(
        .XLEN(32), .SETS(64), .WAYS(2), .CTR_BITS(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic        pt;
        logic [31:0] tgt;
        logic [31:0] pc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  look_vld = 1'b0;
    int    checks = 0;
    int    errors = 0;
    exp_t  mon_e;
    string mon_n;

    // Monitor: one comparison per presented lookup, away from the rising edge.
    always @(negedge clk) begin
        if (look_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_lookup: no expected entry queued (pc=%h)", bus.pc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (bus.hit !== mon_e.hit || bus.predict_taken !== mon_e.pt ||
                    bus.target !== mon_e.tgt) begin
                    errors++;
                    $display("FAIL %s pc=%h: got hit=%b pt=%b tgt=%h, expected hit=%b pt=%b tgt=%h",
                             mon_n, mon_e.pc, bus.hit, bus.predict_taken, bus.target,
                             mon_e.hit, mon_e.pt, mon_e.tgt);
                end
            end
        end
    end

    task automatic look(input string n, input logic [31:0] p,
                        input logic eh, input logic ept, input logic [31:0] et);
        exp_t e;
        e.hit = eh; e.pt = ept; e.tgt = et; e.pc = p;
        bus.pc   = p;
        look_vld = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic train(input logic [6:0] op, input logic [31:0] p,
                         input logic tk, input logic [31:0] tg);
        bus.upd_valid  = 1'b1;
        bus.upd_opcode = op;
        bus.upd_pc     = p;
        bus.upd_taken  = tk;
        bus.upd_target = tg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        bus.flush     = 1'b0;
        look_vld      = 1'b0;
    endtask

    task automatic tr(input logic [6:0] op, input logic [31:0] p,
                      input logic tk, input logic [31:0] tg);
        train(op, p, tk, tg);
        tick();
    endtask

    task automatic lk(input string n, input logic [31:0] p,
                      input logic eh, input logic ept, input logic [31:0] et);
        look(n, p, eh, ept, et);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus.pc = '0; bus.upd_valid = 1'b0; bus.upd_opcode = '0; bus.upd_pc = '0;
        bus.upd_taken = 1'b0; bus.upd_target = '0; bus.flush = 1'b0;
        @(posedge clk); #1;

        // 1. reset state
        lk("in_reset", 32'h100, 0, 0, 32'h0);
        rst_n = 1'b1;
        lk("after_reset", 32'h100, 0, 0, 32'h0);

        // 2. allocate; same-cycle lookup sees old state
        train(OP_BR, 32'h100, 1, 32'h200);
        look("no_bypass", 32'h100, 0, 0, 32'h0);
        tick();
        lk("alloc_weak", 32'h100, 1, 1, 32'h200);

        // 3. counter saturation both ways, target only on taken
        tr(OP_BR, 32'h100, 0, 32'hdead);
        lk("ctr1", 32'h100, 1, 0, 32'h200);
        tr(OP_BR, 32'h100, 0, 32'hdead);
        lk("ctr0", 32'h100, 1, 0, 32'h200);
        tr(OP_BR, 32'h100, 0, 32'hdead);
        tr(OP_BR, 32'h100, 1, 32'h204);
        lk("sat0_then_ctr1", 32'h100, 1, 0, 32'h204);
        tr(OP_BR, 32'h100, 1, 32'h204);
        lk("ctr2", 32'h100, 1, 1, 32'h204);
        tr(OP_BR, 32'h100, 1, 32'h204);
        tr(OP_BR, 32'h100, 1, 32'h204);
        tr(OP_BR, 32'h100, 0, 32'h0);
        lk("sat3_then_ctr2", 32'h100, 1, 1, 32'h204);
        tr(OP_BR, 32'h100, 0, 32'h0);
        lk("ctr1_again", 32'h100, 1, 0, 32'h204);

        // 4. LRU in set 0
        tr(OP_BR, 32'h100, 1, 32'h1a0);
        tr(OP_BR, 32'h200, 1, 32'h2a0);
        tr(OP_BR, 32'h100, 1, 32'h1a0);
        tr(OP_BR, 32'h300, 1, 32'h3a0);
        lk("lru_keep_100", 32'h100, 1, 1, 32'h1a0);
        lk("lru_evict_200", 32'h200, 0, 0, 32'h0);
        lk("lru_new_300", 32'h300, 1, 1, 32'h3a0);
        tr(OP_BR, 32'h100, 0, 32'h0);      // not-taken hit still becomes MRU
        tr(OP_BR, 32'h200, 1, 32'h2a0);
        lk("nt_mru_evict_300", 32'h300, 0, 0, 32'h0);
        lk("nt_mru_keep_100", 32'h100, 1, 1, 32'h1a0);
        lk("pc_lo_ignored", 32'h102, 1, 1, 32'h1a0);
        lk("realloc_200", 32'h200, 1, 1, 32'h2a0);
        tr(OP_BR, 32'h600, 0, 32'h6a0);
        lk("nt_miss_no_alloc", 32'h600, 0, 0, 32'h0);
        lk("nt_miss_keep_200", 32'h200, 1, 1, 32'h2a0);

        // 5. jal forces max counter; other opcodes ignored
        tr(OP_JAL, 32'h40, 1, 32'h80);
        lk("jal_alloc", 32'h40, 1, 1, 32'h80);
        tr(OP_BR, 32'h40, 0, 32'h0);
        lk("jal_ctr3_minus1", 32'h40, 1, 1, 32'h80);
        tr(OP_BR, 32'h40, 0, 32'h0);
        lk("jal_ctr1", 32'h40, 1, 0, 32'h80);
        tr(OP_JAL, 32'h40, 1, 32'h88);
        tr(OP_BR, 32'h40, 0, 32'h0);
        lk("jal_hit_forced_max", 32'h40, 1, 1, 32'h88);
        tr(OP_ALU, 32'h40, 1, 32'h999);
        tr(OP_ALU, 32'h40, 0, 32'h0);
        lk("alu_ignored_hit", 32'h40, 1, 1, 32'h88);
        tr(OP_ALU, 32'h800, 1, 32'h8a0);
        lk("alu_ignored_miss", 32'h800, 0, 0, 32'h0);

        // 6. flush beats training
        train(OP_BR, 32'h500, 1, 32'h5a0);
        bus.flush = 1'b1;
        tick();
        lk("flush_drop_500", 32'h500, 0, 0, 32'h0);
        lk("flush_100", 32'h100, 0, 0, 32'h0);
        lk("flush_200", 32'h200, 0, 0, 32'h0);
        lk("flush_40", 32'h40, 0, 0, 32'h0);
        tr(OP_BR, 32'h100, 1, 32'h1a0);
        lk("post_flush_alloc", 32'h100, 1, 1, 32'h1a0);

        // async reset mid-run: outputs clear before the next rising edge
        rst_n = 1'b0;
        train(OP_BR, 32'h300, 1, 32'h3a0);
        look("async_reset", 32'h100, 0, 0, 32'h0);
        tick();
        rst_n = 1'b1;
        lk("reset_drop_train", 32'h300, 0, 0, 32'h0);
        lk("reset_cleared_100", 32'h100, 0, 0, 32'h0);
        tr(OP_BR, 32'h300, 1, 32'h3a0);
        lk("train_after_release", 32'h300, 1, 1, 32'h3a0);

        // drain: every queued expectation must have been consumed
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected lookups never observed, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
